// File: rtl/tlb_seq_pkg.sv
// Shared types and helpers for the 32-entry MIPS32 joint TLB: entry layout,
// segment codes and the match/translate functions used by lookup and probe.
package tlb_seq_pkg;

  localparam int unsigned IdxW      = 5;
  localparam logic [2:0]  SegKseg0  = 3'b100;
  localparam logic [2:0]  SegKseg1  = 3'b101;
  localparam logic [2:0]  CacheableC = 3'b011;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_lo_t;

  // 90-bit entry, MSB first: VPN2, ASID, PAGEMASK, G, LO0, LO1
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [11:0] pagemask;
    logic        g;
    tlb_lo_t     lo0;
    tlb_lo_t     lo1;
  } tlb_entry_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        invalid;
    logic        modified;
    logic        cache;
  } tlb_xlate_t;

  // Only 4 KB pages exist, so PAGEMASK takes no part in matching.
  function automatic logic tlb_match(tlb_entry_t e, logic [18:0] vpn2, logic [7:0] asid);
    return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
  endfunction

  function automatic tlb_xlate_t tlb_xlate(logic [31:0] vaddr, logic hit, tlb_lo_t lo,
                                           logic store);
    tlb_xlate_t r;
    r = '0;
    if (vaddr[31:29] == SegKseg0 || vaddr[31:29] == SegKseg1) begin
      r.paddr = vaddr & 32'h1FFF_FFFF;
      r.cache = (vaddr[31:29] == SegKseg0);
    end else if (!hit) begin
      r.miss = 1'b1;
    end else begin
      r.paddr    = {lo.pfn, vaddr[11:0]};
      r.invalid  = !lo.v;
      r.modified = lo.v && store && !lo.d;
      r.cache    = (lo.c == CacheableC);
    end
    return r;
  endfunction

endpackage

// File: rtl/tlb_seq_if.sv
// CP0 / fetch / mem facing bundle of the TLB; master is the requester side.
interface tlb_seq_if;
  import tlb_seq_pkg::*;

  logic [IdxW-1:0] r_index;
  tlb_entry_t      r_resp;
  logic            w_valid;
  logic [IdxW-1:0] w_index;
  tlb_entry_t      w_data;
  logic            p_start;
  logic [18:0]     p_vpn2;
  logic [7:0]      p_asid;
  logic            p_busy;
  logic            p_done;
  logic [IdxW-1:0] p_index;
  logic            p_miss;
  logic            qi_req;
  logic [7:0]      qi_asid;
  logic [31:0]     qi_vaddr;
  logic            qi_rvalid;
  logic [31:0]     qi_paddr;
  logic            qi_miss;
  logic            qi_invalid;
  logic            qi_cache;
  logic            qd_req;
  logic [7:0]      qd_asid;
  logic [31:0]     qd_vaddr;
  logic            qd_ren;
  logic            qd_wen;
  logic            qd_rvalid;
  logic [31:0]     qd_paddr;
  logic            qd_miss;
  logic            qd_invalid;
  logic            qd_modified;
  logic            qd_cache;

  modport master (
    output r_index, w_valid, w_index, w_data, p_start, p_vpn2, p_asid,
           qi_req, qi_asid, qi_vaddr, qd_req, qd_asid, qd_vaddr, qd_ren, qd_wen,
    input  r_resp, p_busy, p_done, p_index, p_miss,
           qi_rvalid, qi_paddr, qi_miss, qi_invalid, qi_cache,
           qd_rvalid, qd_paddr, qd_miss, qd_invalid, qd_modified, qd_cache
  );

  modport slave (
    input  r_index, w_valid, w_index, w_data, p_start, p_vpn2, p_asid,
           qi_req, qi_asid, qi_vaddr, qd_req, qd_asid, qd_vaddr, qd_ren, qd_wen,
    output r_resp, p_busy, p_done, p_index, p_miss,
           qi_rvalid, qi_paddr, qi_miss, qi_invalid, qi_cache,
           qd_rvalid, qd_paddr, qd_miss, qd_invalid, qd_modified, qd_cache
  );

endinterface

// File: rtl/tlb_lookup.sv
// Fully-associative combinational lookup: lowest matching index wins and the
// even/odd LO half is picked by vaddr[12].
module tlb_lookup
  import tlb_seq_pkg::*;
#(
  parameter int unsigned Entries = 32
) (
  input  tlb_entry_t      entries_i [Entries],
  input  logic [18:0]     vpn2_i,
  input  logic [7:0]      asid_i,
  input  logic            odd_i,
  output logic            hit_o,
  output logic [IdxW-1:0] index_o,
  output tlb_lo_t         lo_o
);

  logic unused_pagemask;

  always_comb begin
    hit_o           = 1'b0;
    index_o         = '0;
    lo_o            = '0;
    unused_pagemask = 1'b0;
    // Walk downwards so the lowest matching index is the last one written.
    for (int i = Entries - 1; i >= 0; i--) begin
      unused_pagemask = unused_pagemask ^ (^entries_i[i].pagemask);
      if (tlb_match(entries_i[i], vpn2_i, asid_i)) begin
        hit_o   = 1'b1;
        index_o = IdxW'(i);
        lo_o    = odd_i ? entries_i[i].lo1 : entries_i[i].lo0;
      end
    end
  end

endmodule

// File: rtl/tlb_seq.sv
// MIPS32 joint TLB: CP0 read/write, multi-cycle probe scan engine, and
// registered instruction/data translation ports.
module tlb_seq
  import tlb_seq_pkg::*;
#(
  parameter int unsigned TLB_ENTRIES = 32,
  parameter int unsigned PROBE_LANES = 8
) (
  input logic      clk,
  input logic      rst,
  tlb_seq_if.slave bus
);

  localparam int unsigned Groups = TLB_ENTRIES / PROBE_LANES;
  localparam int unsigned GrpW   = (Groups > 1) ? $clog2(Groups) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} probe_st_e;

  tlb_entry_t      entries_q [TLB_ENTRIES];
  tlb_entry_t      entries_d [TLB_ENTRIES];
  probe_st_e       state_q, state_d;
  logic [GrpW-1:0] base_q, base_d;
  logic [18:0]     key_vpn2_q, key_vpn2_d;
  logic [7:0]      key_asid_q, key_asid_d;
  logic [IdxW-1:0] p_index_q, p_index_d;
  logic            p_miss_q, p_miss_d;
  logic [IdxW-1:0] cand;
  logic [IdxW-1:0] lane_idx;
  logic            lane_hit;
  tlb_xlate_t      qi_res_q, qi_res_d, qd_res_q, qd_res_d;
  logic            qi_rvalid_q, qd_rvalid_q;
  logic            qi_hit, qd_hit;
  logic [IdxW-1:0] qi_index, qd_index;
  tlb_lo_t         qi_lo, qd_lo;

  always_comb begin
    entries_d = entries_q;
    if (bus.w_valid) entries_d[bus.w_index] = bus.w_data;
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    key_vpn2_d = key_vpn2_q;
    key_asid_d = key_asid_q;
    p_index_d  = p_index_q;
    p_miss_d   = p_miss_q;
    cand       = '0;
    lane_idx   = '0;
    lane_hit   = 1'b0;
    for (int l = PROBE_LANES - 1; l >= 0; l--) begin
      cand = IdxW'(base_q) * IdxW'(PROBE_LANES) + IdxW'(l);
      if (tlb_match(entries_q[cand], key_vpn2_q, key_asid_q)) begin
        lane_hit = 1'b1;
        lane_idx = cand;
      end
    end
    unique case (state_q)
      StIdle: begin
        if (bus.p_start) begin
          key_vpn2_d = bus.p_vpn2;
          key_asid_d = bus.p_asid;
          base_d     = '0;
          state_d    = StScan;
        end
      end
      StScan: begin
        // A write may create an earlier match, so the scan starts over.
        if (bus.w_valid) begin
          base_d = '0;
        end else if (lane_hit) begin
          p_index_d = lane_idx;
          p_miss_d  = 1'b0;
          state_d   = StDone;
        end else if (base_q == GrpW'(Groups - 1)) begin
          p_index_d = '0;
          p_miss_d  = 1'b1;
          state_d   = StDone;
        end else begin
          base_d = base_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  tlb_lookup #(.Entries(TLB_ENTRIES)) u_lookup_i (
    .entries_i (entries_q),
    .vpn2_i    (bus.qi_vaddr[31:13]),
    .asid_i    (bus.qi_asid),
    .odd_i     (bus.qi_vaddr[12]),
    .hit_o     (qi_hit),
    .index_o   (qi_index),
    .lo_o      (qi_lo)
  );

  tlb_lookup #(.Entries(TLB_ENTRIES)) u_lookup_d (
    .entries_i (entries_q),
    .vpn2_i    (bus.qd_vaddr[31:13]),
    .asid_i    (bus.qd_asid),
    .odd_i     (bus.qd_vaddr[12]),
    .hit_o     (qd_hit),
    .index_o   (qd_index),
    .lo_o      (qd_lo)
  );

  always_comb begin
    qi_res_d = qi_res_q;
    qd_res_d = qd_res_q;
    if (bus.qi_req) qi_res_d = tlb_xlate(bus.qi_vaddr, qi_hit, qi_lo, 1'b0);
    if (bus.qd_req) qd_res_d = tlb_xlate(bus.qd_vaddr, qd_hit, qd_lo, bus.qd_wen);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++) entries_q[i] <= '0;
      state_q     <= StIdle;
      base_q      <= '0;
      key_vpn2_q  <= '0;
      key_asid_q  <= '0;
      p_index_q   <= '0;
      p_miss_q    <= 1'b0;
      qi_res_q    <= '0;
      qd_res_q    <= '0;
      qi_rvalid_q <= 1'b0;
      qd_rvalid_q <= 1'b0;
    end else begin
      entries_q   <= entries_d;
      state_q     <= state_d;
      base_q      <= base_d;
      key_vpn2_q  <= key_vpn2_d;
      key_asid_q  <= key_asid_d;
      p_index_q   <= p_index_d;
      p_miss_q    <= p_miss_d;
      qi_res_q    <= qi_res_d;
      qd_res_q    <= qd_res_d;
      qi_rvalid_q <= bus.qi_req;
      qd_rvalid_q <= bus.qd_req;
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{bus.qd_ren, qi_index, qd_index};

  assign bus.r_resp      = entries_q[bus.r_index];
  assign bus.p_busy      = (state_q == StScan);
  assign bus.p_done      = (state_q == StDone);
  assign bus.p_index     = p_index_q;
  assign bus.p_miss      = p_miss_q;
  assign bus.qi_rvalid   = qi_rvalid_q;
  assign bus.qi_paddr    = qi_res_q.paddr;
  assign bus.qi_miss     = qi_res_q.miss;
  assign bus.qi_invalid  = qi_res_q.invalid;
  assign bus.qi_cache    = qi_res_q.cache;
  assign bus.qd_rvalid   = qd_rvalid_q;
  assign bus.qd_paddr    = qd_res_q.paddr;
  assign bus.qd_miss     = qd_res_q.miss;
  assign bus.qd_invalid  = qd_res_q.invalid;
  assign bus.qd_modified = qd_res_q.modified;
  assign bus.qd_cache    = qd_res_q.cache;

endmodule

// File: tb/tb_tlb_seq.sv
// Bench for tlb_seq: table of translation vectors checked through a
// scoreboard, plus hand sequences for probe timing, restart and reset.
module tb_tlb_seq;
  import tlb_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlb_seq_if bus ();

  tlb_seq #(.TLB_ENTRIES(32), .PROBE_LANES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  tlb_xlate_t qi_exp[$];
  tlb_xlate_t qd_exp[$];

  typedef struct {
    bit          is_d;
    logic [7:0]  asid;
    logic [31:0] vaddr;
    logic        ren;
    logic        wen;
    tlb_xlate_t  exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tlb_lo_t mk_lo(logic [19:0] pfn, logic [2:0] c, logic d, logic v);
    tlb_lo_t r;
    r.pfn = pfn; r.c = c; r.d = d; r.v = v;
    return r;
  endfunction

  function automatic tlb_entry_t mk_entry(logic [18:0] vpn2, logic [7:0] asid, logic g,
                                          tlb_lo_t lo0, tlb_lo_t lo1);
    tlb_entry_t e;
    e.vpn2 = vpn2; e.asid = asid; e.pagemask = 12'h000; e.g = g; e.lo0 = lo0; e.lo1 = lo1;
    return e;
  endfunction

  function automatic tlb_xlate_t res(logic [31:0] pa, logic m, logic inv, logic mod, logic c);
    tlb_xlate_t r;
    r.paddr = pa; r.miss = m; r.invalid = inv; r.modified = mod; r.cache = c;
    return r;
  endfunction

  task automatic write_entry(input logic [4:0] idx, input tlb_entry_t e);
    bus.w_valid = 1'b1; bus.w_index = idx; bus.w_data = e;
    tick();
    bus.w_valid = 1'b0;
  endtask

  task automatic query_d(input logic [7:0] asid, input logic [31:0] va, input logic ren,
                         input logic wen, input tlb_xlate_t exp);
    bus.qd_req = 1'b1; bus.qd_asid = asid; bus.qd_vaddr = va; bus.qd_ren = ren; bus.qd_wen = wen;
    qd_exp.push_back(exp);
    tick();
    bus.qd_req = 1'b0; bus.qd_ren = 1'b0; bus.qd_wen = 1'b0;
  endtask

  task automatic query_i(input logic [7:0] asid, input logic [31:0] va, input tlb_xlate_t exp);
    bus.qi_req = 1'b1; bus.qi_asid = asid; bus.qi_vaddr = va;
    qi_exp.push_back(exp);
    tick();
    bus.qi_req = 1'b0;
  endtask

  // Wait for p_done, counting p_busy cycles seen on the way.
  task automatic wait_done(output int busy, output bit done);
    busy = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (bus.p_done) done = 1'b1;
      else begin
        if (bus.p_busy) busy++;
        tick();
      end
    end
  endtask

  task automatic run_probe(input logic [18:0] vpn2, input logic [7:0] asid,
                           output int busy, output bit done);
    bus.p_vpn2 = vpn2; bus.p_asid = asid; bus.p_start = 1'b1;
    tick();
    bus.p_start = 1'b0;
    wait_done(busy, done);
  endtask

  // Scoreboard: every returned result is matched against the oldest expectation.
  always begin
    tlb_xlate_t e;
    @(posedge clk);
    #1;
    if (bus.qd_rvalid) begin
      if (qd_exp.size() == 0) check("qd_unexpected_rvalid", 1, 0);
      else begin
        e = qd_exp.pop_front();
        check("qd_result", {bus.qd_paddr, bus.qd_miss, bus.qd_invalid, bus.qd_modified,
                            bus.qd_cache}, e);
      end
    end
    if (bus.qi_rvalid) begin
      if (qi_exp.size() == 0) check("qi_unexpected_rvalid", 1, 0);
      else begin
        e = qi_exp.pop_front();
        check("qi_result", {bus.qi_paddr, bus.qi_miss, bus.qi_invalid, 1'b0, bus.qi_cache}, e);
      end
    end
  end

  initial begin
    int         busy;
    bit         done;
    bit         seen;
    tlb_entry_t e3, e7, e9, e20, e1;

    bus.r_index = '0; bus.w_valid = 1'b0; bus.w_index = '0; bus.w_data = '0;
    bus.p_start = 1'b0; bus.p_vpn2 = '0; bus.p_asid = '0;
    bus.qi_req = 1'b0; bus.qi_asid = '0; bus.qi_vaddr = '0;
    bus.qd_req = 1'b0; bus.qd_asid = '0; bus.qd_vaddr = '0; bus.qd_ren = 1'b0;
    bus.qd_wen = 1'b0;
    #2 rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();

    check("reset_outputs", {bus.p_busy, bus.p_done, bus.p_index, bus.p_miss, bus.qi_rvalid,
                            bus.qd_rvalid, bus.qi_paddr[15:0], bus.qd_paddr[15:0]}, 0);
    for (int i = 0; i < 32; i++) begin
      bus.r_index = 5'(i);
      #1;
      check($sformatf("reset_r_resp[%0d]", i), {38'd0, bus.r_resp[89:64]} | 64'(bus.r_resp[63:0]), 0);
    end

    query_i(8'h00, 32'h0040_0000, res(32'h0, 1, 0, 0, 0));

    e3  = mk_entry(19'h00200, 8'h05, 1'b0, mk_lo(20'h01234, 3'd3, 1, 1),
                   mk_lo(20'h05678, 3'd2, 0, 0));
    e7  = mk_entry(19'h00300, 8'h09, 1'b1, mk_lo(20'hABCDE, 3'd3, 0, 1),
                   mk_lo(20'h11111, 3'd3, 1, 1));
    write_entry(5'd3, e3);
    write_entry(5'd7, e7);
    bus.r_index = 5'd3;
    #1;
    check("r_resp_idx3_hi", 64'(bus.r_resp[89:45]), 64'(e3[89:45]));
    check("r_resp_idx3_lo", 64'(bus.r_resp[44:0]), 64'(e3[44:0]));

    vecs[0]  = '{1'b1, 8'h05, 32'h0040_0ABC, 1'b1, 1'b0, res(32'h0123_4ABC, 0, 0, 0, 1)};
    vecs[1]  = '{1'b1, 8'h06, 32'h0040_0ABC, 1'b1, 1'b0, res(32'h0, 1, 0, 0, 0)};
    vecs[2]  = '{1'b1, 8'h05, 32'h0040_1000, 1'b1, 1'b0, res(32'h0567_8000, 0, 1, 0, 0)};
    vecs[3]  = '{1'b1, 8'h05, 32'h0040_1000, 1'b0, 1'b1, res(32'h0567_8000, 0, 1, 0, 0)};
    vecs[4]  = '{1'b1, 8'h22, 32'h0060_0123, 1'b0, 1'b1, res(32'hABCD_E123, 0, 0, 1, 1)};
    vecs[5]  = '{1'b1, 8'h22, 32'h0060_0123, 1'b1, 1'b0, res(32'hABCD_E123, 0, 0, 0, 1)};
    vecs[6]  = '{1'b1, 8'h22, 32'h0060_0123, 1'b0, 1'b0, res(32'hABCD_E123, 0, 0, 0, 1)};
    vecs[7]  = '{1'b0, 8'h05, 32'h0040_0ABC, 1'b0, 1'b0, res(32'h0123_4ABC, 0, 0, 0, 1)};
    vecs[8]  = '{1'b0, 8'h05, 32'h8000_1000, 1'b0, 1'b0, res(32'h0000_1000, 0, 0, 0, 1)};
    vecs[9]  = '{1'b0, 8'h05, 32'hBFC0_0000, 1'b0, 1'b0, res(32'h1FC0_0000, 0, 0, 0, 0)};
    vecs[10] = '{1'b0, 8'h05, 32'h0060_0000, 1'b0, 1'b0, res(32'hABCD_E000, 0, 0, 0, 1)};
    vecs[11] = '{1'b0, 8'h05, 32'hC000_0000, 1'b0, 1'b0, res(32'h0, 1, 0, 0, 0)};
    vecs[12] = '{1'b1, 8'h01, 32'h0060_1FFF, 1'b0, 1'b1, res(32'h1111_1FFF, 0, 0, 0, 1)};
    vecs[13] = '{1'b1, 8'h05, 32'hA000_0010, 1'b0, 1'b1, res(32'h0000_0010, 0, 0, 0, 0)};

    foreach (vecs[i]) begin
      if (vecs[i].is_d) query_d(vecs[i].asid, vecs[i].vaddr, vecs[i].ren, vecs[i].wen,
                                vecs[i].exp);
      else query_i(vecs[i].asid, vecs[i].vaddr, vecs[i].exp);
    end
    tick();
    check("qd_hold_rvalid", bus.qd_rvalid, 0);
    check("qd_hold_paddr", bus.qd_paddr, 32'h0000_0010);

    // A write and a query in the same cycle: the query sees the old contents.
    e9 = mk_entry(19'h00400, 8'h05, 1'b0, mk_lo(20'h00042, 3'd3, 1, 1), '0);
    bus.w_valid = 1'b1; bus.w_index = 5'd9; bus.w_data = e9;
    query_d(8'h05, 32'h0080_0010, 1'b1, 1'b0, res(32'h0, 1, 0, 0, 0));
    bus.w_valid = 1'b0;
    query_d(8'h05, 32'h0080_0010, 1'b1, 1'b0, res(32'h0004_2010, 0, 0, 0, 1));

    e20 = mk_entry(19'h00500, 8'h0A, 1'b0, mk_lo(20'h00500, 3'd3, 1, 1), '0);
    write_entry(5'd20, e20);
    run_probe(19'h00500, 8'h0A, busy, done);
    check("probe20_done", done, 1);
    check("probe20_busy_cycles", busy, 3);
    check("probe20_index", bus.p_index, 20);
    check("probe20_miss", bus.p_miss, 0);
    tick();
    check("probe20_done_pulse", bus.p_done, 0);
    check("probe20_index_hold", bus.p_index, 20);

    run_probe(19'h7FFFF, 8'h0A, busy, done);
    check("probe_absent_done", done, 1);
    check("probe_absent_busy_cycles", busy, 4);
    check("probe_absent_miss", bus.p_miss, 1);
    check("probe_absent_index", bus.p_index, 0);
    tick();

    // Write mid-scan restarts at base 0; a start pulse while busy is dropped.
    e1 = mk_entry(19'h00500, 8'h0A, 1'b0, mk_lo(20'h00777, 3'd3, 1, 1), '0);
    bus.p_vpn2 = 19'h00500; bus.p_asid = 8'h0A; bus.p_start = 1'b1;
    tick();
    bus.p_start = 1'b1; bus.p_vpn2 = 19'h7FFFF;
    bus.w_valid = 1'b1; bus.w_index = 5'd1; bus.w_data = e1;
    tick();
    bus.p_start = 1'b0; bus.w_valid = 1'b0;
    wait_done(busy, done);
    check("probe_restart_done", done, 1);
    check("probe_restart_index", bus.p_index, 1);
    check("probe_restart_miss", bus.p_miss, 0);
    tick();
    check("probe_after_busy_start_idle", bus.p_busy, 0);

    bus.p_vpn2 = 19'h7FFFF; bus.p_start = 1'b1;
    tick();
    bus.p_start = 1'b0;
    tick();
    check("midprobe_busy_before_rst", bus.p_busy, 1);
    rst = 1'b0;
    #1;
    check("midprobe_rst_busy", bus.p_busy, 0);
    check("midprobe_rst_done", bus.p_done, 0);
    check("midprobe_rst_result", {bus.p_index, bus.p_miss}, 0);
    tick(); tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen = seen | bus.p_done;
    end
    check("midprobe_no_done", seen, 0);
    bus.r_index = 5'd20;
    #1;
    check("rst_clears_entry20", 64'(bus.r_resp[89:45]) | 64'(bus.r_resp[44:0]), 0);

    tick(); tick();
    check("qi_scoreboard_drained", qi_exp.size(), 0);
    check("qd_scoreboard_drained", qd_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_seq.md
Name: tlb_seq

Overview:
- 32-entry MIPS32 joint TLB. Responder to the CP0 block.
- Accepts TLBWI/TLBWR writes, TLBR reads and TLBP probes from CP0. Also serves instruction-side and data-side address translation for fetch and mem.
- Probes run on a multi-cycle scan engine. Translations return one cycle after the request to ease timing.

Parameters:
- TLB_ENTRIES, 32, number of entries; index width is 5 bits.
- PROBE_LANES, 8, entries compared per probe cycle; must divide TLB_ENTRIES.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
r_index  in  5  TLBR entry select
r_resp  out  90  entry[r_index], combinational
w_valid  in  1  write strobe
w_index  in  5  write entry select
w_data  in  90  entry data {VPN2[89:71], ASID[70:63], PAGEMASK[62:51], G[50], LO0[49:25], LO1[24:0]}
p_start  in  1  probe start pulse
p_vpn2  in  19  probe VPN2
p_asid  in  8  probe ASID
p_busy  out  1  probe in progress
p_done  out  1  one-cycle pulse, result valid
p_index  out  5  matching index
p_miss  out  1  no match
qi_req  in  1  instruction query request
qi_asid  in  8  current ASID
qi_vaddr  in  32  fetch address
qi_rvalid  out  1  result valid
qi_paddr  out  32  physical address
qi_miss  out  1  refill miss
qi_invalid  out  1  V=0
qi_cache  out  1  cacheable
qd_req  in  1  data query request
qd_asid  in  8  current ASID
qd_vaddr  in  32  data address
qd_ren  in  1  load
qd_wen  in  1  store
qd_rvalid  out  1  result valid
qd_paddr  out  32  physical address
qd_miss  out  1  refill miss
qd_invalid  out  1  V=0
qd_modified  out  1  store to clean page
qd_cache  out  1  cacheable

Behaviour:
- LO field layout: {PFN[24:5], C[4:2], D[1], V[0]}.
- Reset (rst=0, async):
  - All entries cleared to 0.
  - Probe FSM to IDLE.
  - All outputs 0, except r_resp, which follows entry[r_index] (0).
- Write: on clk edge with w_valid=1, entry[w_index] <= w_data.
  - Any read, query or probe in the same cycle sees the old contents.
- Match rule: entry.VPN2 == vpn2 && (entry.G || entry.ASID == asid).
  - Only 4 KB pages are supported. PAGEMASK is stored and returned by r_resp but ignored in matching.
  - On multiple matches, the lowest index wins.
- Probe FSM: IDLE -> SCAN -> DONE -> IDLE.
  - IDLE: p_start=1 latches p_vpn2/p_asid, clears the base counter, moves to SCAN.
  - SCAN: p_busy=1. Each cycle compares entries [base, base+PROBE_LANES-1] and records the first hit.
    - Ends early on a hit, or after TLB_ENTRIES/PROBE_LANES cycles. Default latency is at most 4 SCAN cycles.
  - DONE: p_done=1 for one cycle. p_index = hit index (0 on miss), p_miss = !hit.
    - p_index/p_miss hold until the next probe completes.
  - p_start while busy is ignored.
  - w_valid during SCAN restarts the scan at base 0 with the same latched key.
- Translation: qX_req sampled at edge N; registered results valid with qX_rvalid=1 during cycle N+1.
  - Results hold when there is no request; rvalid=0.
  - kseg0 (vaddr[31:29]=100): paddr = vaddr & 0x1FFF_FFFF, cache=1, no exceptions.
  - kseg1 (101): paddr = vaddr & 0x1FFF_FFFF, cache=0, no exceptions.
  - Mapped regions: odd/even half selected by vaddr[12].
    - paddr = {PFN[19:0], vaddr[11:0]}.
    - miss = no match.
    - invalid = match && !V.
    - modified = data only: match && V && qd_wen && !D.
    - cache = (C == 3'b011).
  - On a miss, paddr = 0 and cache = 0.
  - qd_ren=qd_wen=0 with qd_req=1 still translates; modified=0 in that case.
- Both query ports operate independently of each other and of the probe.

Decomposition:
- Shared package/defines:
  - Entry field ranges: VPN2, ASID, PAGEMASK, G, LO0, LO1.
  - LO sub-fields: PFN, C, D, V.
  - Segment codes KSEG0/KSEG1.
  - Cacheable code 3'b011.
- One sub-module, tlb_lookup: combinational match of one (vpn2, asid, vaddr[12]) against all entries, returning hit, index, lo.
  - Instantiated for the instruction port and the data port.
  - The probe reuses its compare function per lane.

Test Plan:
- Reset, then query qi_vaddr=0x0040_0000 -> qi_rvalid=1 next cycle, qi_miss=1, qi_paddr=0. Check r_resp=0 for every r_index.
- Write index 3: VPN2=0x00200, ASID=0x05, G=0, LO0={PFN 0x01234, C=3, D=1, V=1}. Data query 0x0040_0ABC, asid 5 -> paddr 0x0123_4ABC, cache=1. Same query with asid 6 -> miss=1.
- Same entry with LO1 V=0: query 0x0040_1000 -> invalid=1. Store to an LO0 page with D=0 -> modified=1; load to the same page -> modified=0.
- Write a matching entry at index 20, then p_start -> p_busy high for 3 cycles, p_done pulse, p_index=20, p_miss=0. Probe for an absent VPN2 -> p_miss=1 after 4 SCAN cycles.
- During SCAN, write a matching entry at index 1 -> scan restarts, p_index=1. p_start while busy is ignored.
- qi_vaddr=0x8000_1000 -> paddr 0x0000_1000, cache=1. qi_vaddr=0xBFC0_0000 -> paddr 0x1FC0_0000, cache=0. Assert rst mid-probe -> p_busy=0 immediately, no p_done.
